// File: rtl/cam_pkg.sv
// cam_pkg: shared types for the CAM front-end controller.
//   cam_state_e : controller FSM states
//   cam_resp_t  : registered response word (hit, full, index)
// The response index field is sized for the default 16-row array. A
// deeper array needs CAM_MAX_DEPTH raised to match.
package cam_pkg;

   localparam int CAM_MAX_DEPTH = 16;
   localparam int CAM_IDX_W     = $clog2(CAM_MAX_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      SEARCH,
      CAPTURE,
      RESP
   } cam_state_e;

   typedef struct packed {
      logic                 hit;
      logic                 full;
      logic [CAM_IDX_W-1:0] index;
   } cam_resp_t;

endpackage

// File: rtl/prio_enc.sv
// prio_enc: lowest-set-bit priority encoder.
//   vec_i : request vector, bit 0 has the highest priority
//   idx_o : index of the lowest set bit (0 when vec_i is all zero)
//   any_o : at least one bit of vec_i is set
module prio_enc #(
   parameter int N  = 16,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  vec_i,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = IW'(i);
         end
      end
   end

   assign any_o = |vec_i;

endmodule

// File: rtl/cam_ctrl.sv
// cam_ctrl: front-end controller for a DEPTH-row CAM array.
//   Host side : req_valid_i/req_ready_o/req_write_i/req_data_i request
//               handshake; resp_valid_o/resp_ready_i response handshake
//               carrying resp_hit_o, resp_full_o, resp_index_o.
//   Row side  : row_data_o + row_write_enable_o (one-hot write strobe),
//               row_search_enable_o + row_search_data_o (broadcast key),
//               row_match_i / row_valid_i returned by every row.
// Writes allocate the lowest free row; searches report the lowest valid
// matching row. One request is in flight at a time and the response is
// held until the host accepts it.
module cam_ctrl
   import cam_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 16,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_write_i,
   input  logic [WIDTH-1:0] req_data_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic             resp_hit_o,
   output logic             resp_full_o,
   output logic [IDX_W-1:0] resp_index_o,
   output logic [WIDTH-1:0] row_data_o,
   output logic [DEPTH-1:0] row_write_enable_o,
   output logic             row_search_enable_o,
   output logic [WIDTH-1:0] row_search_data_o,
   input  logic [DEPTH-1:0] row_match_i,
   input  logic [DEPTH-1:0] row_valid_i
);

   cam_state_e       state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   cam_resp_t        resp_q, resp_d;

   logic [DEPTH-1:0] free_vec;
   logic [DEPTH-1:0] hit_vec;
   logic [IDX_W-1:0] alloc_idx;
   logic [IDX_W-1:0] hit_idx;
   logic             free_any;
   logic             hit_any;

   assign free_vec = ~row_valid_i;
   // Unwritten rows may hold reset contents equal to the key; mask them.
   assign hit_vec  = row_match_i & row_valid_i;

   prio_enc #(.N(DEPTH), .IW(IDX_W)) u_alloc_enc (
      .vec_i (free_vec),
      .idx_o (alloc_idx),
      .any_o (free_any)
   );

   prio_enc #(.N(DEPTH), .IW(IDX_W)) u_hit_enc (
      .vec_i (hit_vec),
      .idx_o (hit_idx),
      .any_o (hit_any)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         resp_q  <= resp_d;
      end
   end

   // The request kind is carried by the WRITE/SEARCH state itself, so only
   // the data word needs latching at the handshake.
   always_comb begin
      state_d             = state_q;
      data_d              = data_q;
      resp_d              = resp_q;
      req_ready_o         = 1'b0;
      resp_valid_o        = 1'b0;
      resp_hit_o          = 1'b0;
      resp_full_o         = 1'b0;
      resp_index_o        = '0;
      row_data_o          = '0;
      row_write_enable_o  = '0;
      row_search_enable_o = 1'b0;
      row_search_data_o   = '0;

      case (state_q)
         IDLE: begin
            // Ready is masked while reset is held so every output reads 0.
            req_ready_o = ~reset;
            if (req_valid_i) begin
               data_d  = req_data_i;
               state_d = req_write_i ? WRITE : SEARCH;
            end
         end

         WRITE: begin
            row_data_o = data_q;
            if (free_any) begin
               row_write_enable_o = DEPTH'(1) << alloc_idx;
               resp_d = '{hit: 1'b1, full: 1'b0, index: CAM_IDX_W'(alloc_idx)};
            end else begin
               resp_d = '{hit: 1'b0, full: 1'b1, index: '0};
            end
            state_d = RESP;
         end

         SEARCH: begin
            row_search_enable_o = 1'b1;
            row_search_data_o   = data_q;
            state_d             = CAPTURE;
         end

         // Rows present their match vector one cycle after the key arrives;
         // the key stays on the bus while it is sampled.
         CAPTURE: begin
            row_search_enable_o = 1'b1;
            row_search_data_o   = data_q;
            resp_d = '{hit: hit_any, full: 1'b0, index: CAM_IDX_W'(hit_idx)};
            state_d = RESP;
         end

         RESP: begin
            resp_valid_o = 1'b1;
            resp_hit_o   = resp_q.hit;
            resp_full_o  = resp_q.full;
            resp_index_o = IDX_W'(resp_q.index);
            if (resp_ready_i) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cam_ctrl.sv
module tb_cam_ctrl;

   localparam int WIDTH = 32;
   localparam int DEPTH = 16;
   localparam int IDX_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             req_valid_i = 1'b0;
   logic             req_ready_o;
   logic             req_write_i = 1'b0;
   logic [WIDTH-1:0] req_data_i = '0;
   logic             resp_valid_o;
   logic             resp_ready_i = 1'b0;
   logic             resp_hit_o;
   logic             resp_full_o;
   logic [IDX_W-1:0] resp_index_o;
   logic [WIDTH-1:0] row_data_o;
   logic [DEPTH-1:0] row_write_enable_o;
   logic             row_search_enable_o;
   logic [WIDTH-1:0] row_search_data_o;
   logic [DEPTH-1:0] row_match_i;
   logic [DEPTH-1:0] row_valid_i;

   always #5 clk = ~clk;

   cam_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk                 (clk),
      .reset               (reset),
      .req_valid_i         (req_valid_i),
      .req_ready_o         (req_ready_o),
      .req_write_i         (req_write_i),
      .req_data_i          (req_data_i),
      .resp_valid_o        (resp_valid_o),
      .resp_ready_i        (resp_ready_i),
      .resp_hit_o          (resp_hit_o),
      .resp_full_o         (resp_full_o),
      .resp_index_o        (resp_index_o),
      .row_data_o          (row_data_o),
      .row_write_enable_o  (row_write_enable_o),
      .row_search_enable_o (row_search_enable_o),
      .row_search_data_o   (row_search_data_o),
      .row_match_i         (row_match_i),
      .row_valid_i         (row_valid_i)
   );

   // Behavioural CAM rows: reset contents are zero, match is raw (unmasked).
   logic [WIDTH-1:0] row_mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_valid_i <= '0;
         for (int i = 0; i < DEPTH; i++) row_mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (row_write_enable_o[i]) begin
               row_valid_i[i] <= 1'b1;
               row_mem[i]     <= row_data_o;
            end
         end
      end
   end

   always_comb begin
      row_match_i = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (row_search_enable_o && row_mem[i] == row_search_data_o) row_match_i[i] = 1'b1;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic idle_check(input string tag);
      chk({tag, " idle req_ready"}, req_ready_o, 1);
      chk({tag, " idle outputs"},
          {resp_valid_o, resp_hit_o, resp_full_o, resp_index_o, row_write_enable_o,
           row_search_enable_o, row_data_o, row_search_data_o}, 0);
   endtask

   // Reference model: the rows as an ordered list of written keys.
   logic [WIDTH-1:0] model_keys[$];

   task automatic model_req(input logic wr, input logic [WIDTH-1:0] d,
                            output logic hit, output logic full, output logic [IDX_W-1:0] idx);
      hit = 1'b0; full = 1'b0; idx = '0;
      if (wr) begin
         if (model_keys.size() < DEPTH) begin
            idx = IDX_W'(model_keys.size());
            hit = 1'b1;
            model_keys.push_back(d);
         end else begin
            full = 1'b1;
         end
      end else begin
         foreach (model_keys[k]) begin
            if (!hit && model_keys[k] == d) begin
               hit = 1'b1;
               idx = IDX_W'(k);
            end
         end
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk({tag, " in-reset req_ready"}, req_ready_o, 0);
      chk({tag, " in-reset resp_valid"}, resp_valid_o, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      idle_check({tag, " post-reset"});
      model_keys.delete();
   endtask

   // One request/response with latency, strobe and stall checks.
   task automatic xact(input string tag, input logic wr, input logic [WIDTH-1:0] d, input int stall,
                       input logic eh, input logic ef, input logic [IDX_W-1:0] ei);
      int n; int c; int strobe_c; bit got; bit data_ok;
      logic [DEPTH-1:0] strobe; logic [7:0] se_mask;
      logic rh, rf; logic [IDX_W-1:0] ri;
      n = 0;
      while (!req_ready_o && n < 20) begin @(negedge clk); n++; end
      chk({tag, " req_ready"}, req_ready_o, 1);
      req_valid_i = 1'b1; req_write_i = wr; req_data_i = d;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0; req_write_i = 1'b0; req_data_i = '0;
      c = 1; strobe = '0; strobe_c = 0; se_mask = '0; data_ok = 1'b1; got = 1'b0;
      while (c <= 6) begin
         if (row_write_enable_o != '0) begin
            strobe |= row_write_enable_o; strobe_c = c;
            if (row_data_o !== d) data_ok = 1'b0;
         end
         if (row_search_enable_o) begin
            se_mask[c] = 1'b1;
            if (row_search_data_o !== d) data_ok = 1'b0;
         end
         if (resp_valid_o) begin got = 1'b1; break; end
         @(negedge clk); c++;
      end
      chk({tag, " resp seen"}, got, 1);
      chk({tag, " resp latency"}, c, wr ? 2 : 3);
      chk({tag, " write strobe"}, strobe, (wr && eh) ? (DEPTH'(1) << ei) : '0);
      chk({tag, " strobe cycle"}, strobe_c, (wr && eh) ? 1 : 0);
      chk({tag, " search enable cycles"}, se_mask, wr ? 8'h00 : 8'h06);
      chk({tag, " row bus data"}, data_ok, 1);
      chk({tag, " hit"}, resp_hit_o, eh);
      chk({tag, " full"}, resp_full_o, ef);
      chk({tag, " index"}, resp_index_o, ei);
      rh = resp_hit_o; rf = resp_full_o; ri = resp_index_o;
      for (int s = 0; s < stall; s++) begin
         // A stray request during the stall must be ignored.
         req_valid_i = 1'b1; req_write_i = 1'($urandom); req_data_i = $urandom;
         @(negedge clk);
         chk({tag, " stall resp stable"}, {resp_valid_o, resp_hit_o, resp_full_o, resp_index_o},
             {1'b1, rh, rf, ri});
         chk({tag, " stall req_ready"}, req_ready_o, 0);
      end
      req_valid_i = 1'b0; req_write_i = 1'b0; req_data_i = '0;
      resp_ready_i = 1'b1;
      @(negedge clk);
      resp_ready_i = 1'b0;
      idle_check({tag, " after resp"});
   endtask

   typedef struct {
      bit               rst;
      bit               wr;
      logic [WIDTH-1:0] d;
      int               stall;
      bit               eh;
      bit               ef;
      logic [IDX_W-1:0] ei;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit rst, bit wr, logic [WIDTH-1:0] d, int stall,
                               bit eh, bit ef, logic [IDX_W-1:0] ei);
      vec_t v;
      v.rst = rst; v.wr = wr; v.d = d; v.stall = stall; v.eh = eh; v.ef = ef; v.ei = ei;
      vecs.push_back(v);
   endfunction

   initial begin
      #100000000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] pool [6];
      logic mh, mf; logic [IDX_W-1:0] mi;
      logic wr; logic [WIDTH-1:0] d;

      add(1, 1, 32'hDEADBEEF, 0, 1, 0, 0);
      add(1, 0, 32'h0,        0, 0, 0, 0);   // nothing written: zero key must miss
      add(1, 1, 32'hA,        0, 1, 0, 0);
      add(0, 1, 32'hB,        0, 1, 0, 1);
      add(0, 1, 32'hC,        0, 1, 0, 2);
      add(0, 0, 32'hB,        1, 1, 0, 1);
      add(0, 0, 32'h5,        0, 0, 0, 0);
      add(1, 1, 32'h11,       0, 1, 0, 0);
      add(0, 1, 32'h22,       0, 1, 0, 1);
      add(0, 1, 32'h77,       0, 1, 0, 2);
      add(0, 1, 32'h33,       0, 1, 0, 3);
      add(0, 1, 32'h44,       0, 1, 0, 4);
      add(0, 1, 32'h77,       0, 1, 0, 5);
      add(0, 0, 32'h77,       0, 1, 0, 2);   // duplicate key: lowest row wins
      for (int i = 6; i < DEPTH; i++) add(0, 1, 32'h1000 + i, 0, 1, 0, IDX_W'(i));
      add(0, 1, 32'h1234,     5, 0, 1, 0);   // array full, response held 5 cycles
      add(0, 0, 32'h44,       2, 1, 0, 4);
      add(0, 0, 32'h1234,     0, 0, 0, 0);
      add(0, 0, 32'h0,        0, 0, 0, 0);

      #12;
      do_reset("init");

      foreach (vecs[k]) begin
         if (vecs[k].rst) do_reset($sformatf("vec%0d", k));
         xact($sformatf("vec%0d", k), vecs[k].wr, vecs[k].d, vecs[k].stall,
              vecs[k].eh, vecs[k].ef, vecs[k].ei);
      end

      // Reset arriving while the controller is in CAPTURE.
      @(negedge clk);
      req_valid_i = 1'b1; req_write_i = 1'b0; req_data_i = 32'h44;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0; req_data_i = '0;
      @(negedge clk);
      chk("capture search enable", row_search_enable_o, 1);
      reset = 1'b1;
      #1;
      chk("capture reset outputs",
          {req_ready_o, resp_valid_o, resp_hit_o, resp_full_o, resp_index_o, row_write_enable_o,
           row_search_enable_o, row_data_o, row_search_data_o}, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      idle_check("capture reset release");
      model_keys.delete();

      // Randomised traffic against the list model.
      pool[0] = 32'h0; pool[1] = 32'h5A5A5A5A; pool[2] = 32'h1; pool[3] = 32'hFFFFFFFF;
      pool[4] = 32'h77; pool[5] = 32'h80000000;
      for (int t = 0; t < 80; t++) begin
         wr = 1'($urandom_range(0, 1));
         d  = ($urandom_range(0, 5) == 0) ? 32'($urandom) : pool[$urandom_range(0, 5)];
         model_req(wr, d, mh, mf, mi);
         xact($sformatf("rnd%0d", t), wr, d, int'($urandom_range(0, 3)), mh, mf, mi);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
